// File: rtl/frame_buf_pingpong.sv
// -----------------------------------------------------------------------------
// frame_buf_pingpong
// Double-buffered (ping-pong) frame store between a pixel writer and a display
// reader. The writer fills one bank while the reader scans the other; the banks
// trade places at a display frame start once a complete frame is waiting.
//
// Ports
//   i_clk, i_rstn        clock (rising edge), synchronous active-low reset
//   i_data_valid/o_data_ready, i_data, i_sof
//                        write pixel stream; i_sof marks the first pixel
//   i_rd_en, i_rd_addr   read request, raster address
//   o_rd_data, o_rd_valid
//                        read response, one cycle after the request
//   i_rd_frame_start     display frame start pulse
//   o_swap               one-cycle pulse when the banks swap
//   o_wr_bank            bank being written (read bank is the other one)
//   o_sync_err           sticky: start-of-frame seen in the middle of a frame
//   o_drop_cnt           saturating count of discarded frames (DROP_MODE=1)
// -----------------------------------------------------------------------------
module frame_buf_pingpong #(
    parameter int unsigned  DW        = 12,
    parameter int unsigned  H_ACTIVE  = 640,
    parameter int unsigned  V_ACTIVE  = 480,
    parameter int unsigned  DROP_MODE = 0,
    localparam int unsigned NPIX      = H_ACTIVE * V_ACTIVE,
    localparam int unsigned AW        = $clog2(NPIX)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_data_valid,
    output logic          o_data_ready,
    input  logic [DW-1:0] i_data,
    input  logic          i_sof,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_valid,
    input  logic          i_rd_frame_start,
    output logic          o_swap,
    output logic          o_wr_bank,
    output logic          o_sync_err,
    output logic [15:0]   o_drop_cnt
);

    localparam logic [1:0] ST_WAIT_SOF = 2'd0;
    localparam logic [1:0] ST_FILL     = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [AW:0]   NPIX_W    = (AW + 1)'(NPIX);
    localparam logic          DROP      = (DROP_MODE != 0);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          ready_q, ready_d;
    logic          swap_q, swap_d;
    logic          sync_err_q, sync_err_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          wr_en_q, wr_en_d;
    logic          wr_sel_q, wr_sel_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;

    logic          hs;
    logic          rd_oor;

    logic [DW-1:0] mem0 [NPIX];
    logic [DW-1:0] mem1 [NPIX];

    assign hs     = i_data_valid & ready_q;
    assign rd_oor = ({1'b0, i_rd_addr} >= NPIX_W);

    // Write FSM next-state and write-pipeline request
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_bank_d  = wr_bank_q;
        swap_d     = 1'b0;
        sync_err_d = sync_err_q;
        drop_cnt_d = drop_cnt_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_bank_q;
        wr_addr_d  = addr_q;
        wr_data_d  = i_data;

        case (state_q)
            ST_WAIT_SOF: begin
                if (hs && i_sof) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    addr_d    = AW'(1);
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (hs) begin
                    wr_en_d = 1'b1;
                    if (i_sof) begin
                        // Early start-of-frame: resynchronise onto the new frame
                        sync_err_d = 1'b1;
                        wr_addr_d  = '0;
                        addr_d     = AW'(1);
                    end else if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (DROP && hs && i_sof && (drop_cnt_q != 16'hFFFF)) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                // Only a frame already complete before this edge may swap
                if (i_rd_frame_start) begin
                    wr_bank_d = ~wr_bank_q;
                    swap_d    = 1'b1;
                    state_d   = ST_WAIT_SOF;
                end
            end
            default: begin
                state_d = ST_WAIT_SOF;
                addr_d  = '0;
            end
        endcase

        ready_d = DROP || (state_d != ST_HOLD);
    end

    // Control and write-pipeline registers
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ST_WAIT_SOF;
            addr_q     <= '0;
            wr_bank_q  <= 1'b0;
            ready_q    <= 1'b1;
            swap_q     <= 1'b0;
            sync_err_q <= 1'b0;
            drop_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_bank_q  <= wr_bank_d;
            ready_q    <= ready_d;
            swap_q     <= swap_d;
            sync_err_q <= sync_err_d;
            drop_cnt_q <= drop_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Bank RAM write port; a write latched before reset still completes
    always_ff @(posedge i_clk) begin
        if (wr_en_q && !wr_sel_q) begin
            mem0[wr_addr_q] <= wr_data_q;
        end
        if (wr_en_q && wr_sel_q) begin
            mem1[wr_addr_q] <= wr_data_q;
        end
    end

    // Read port: bank chosen from wr_bank_q at request time
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= i_rd_en;
            if (i_rd_en) begin
                if (rd_oor) begin
                    rd_data_q <= '0;
                end else if (wr_bank_q) begin
                    rd_data_q <= mem0[i_rd_addr];
                end else begin
                    rd_data_q <= mem1[i_rd_addr];
                end
            end
        end
    end

    assign o_data_ready = ready_q;
    assign o_swap       = swap_q;
    assign o_wr_bank    = wr_bank_q;
    assign o_sync_err   = sync_err_q;
    assign o_drop_cnt   = drop_cnt_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_data_q;

endmodule

// File: tb/tb_frame_buf_pingpong.sv
// -----------------------------------------------------------------------------
// Bench for frame_buf_pingpong. Two instances share one stimulus stream:
//   dut0: 4x2 (NPIX=8), backpressure when no free bank
//   dut1: 3x2 (NPIX=6), discard when no free bank; addresses 6,7 are out of range
// A frame-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_frame_buf_pingpong;

    localparam int unsigned DW = 12;

    logic          i_clk = 1'b0;
    logic          i_rstn;
    logic          valid, sof, rd_en, frame_start;
    logic [DW-1:0] data;
    logic [2:0]    rd_addr;

    logic [1:0]    rdy, swp, bank, serr, rvld;
    logic [DW-1:0] rdat0, rdat1;
    logic [15:0]   drp0, drp1;

    always #5 i_clk = ~i_clk;

    frame_buf_pingpong #(.DW(DW), .H_ACTIVE(4), .V_ACTIVE(2), .DROP_MODE(0)) u_dut0 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_data_valid(valid), .o_data_ready(rdy[0]),
        .i_data(data), .i_sof(sof), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rdat0), .o_rd_valid(rvld[0]), .i_rd_frame_start(frame_start),
        .o_swap(swp[0]), .o_wr_bank(bank[0]), .o_sync_err(serr[0]), .o_drop_cnt(drp0)
    );

    frame_buf_pingpong #(.DW(DW), .H_ACTIVE(3), .V_ACTIVE(2), .DROP_MODE(1)) u_dut1 (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_data_valid(valid), .o_data_ready(rdy[1]),
        .i_data(data), .i_sof(sof), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rdat1), .o_rd_valid(rvld[1]), .i_rd_frame_start(frame_start),
        .o_swap(swp[1]), .o_wr_bank(bank[1]), .o_sync_err(serr[1]), .o_drop_cnt(drp1)
    );

    // Reference model state (per instance)
    logic          m_bank [2];
    logic          m_hold [2];
    logic          m_act  [2];
    logic          m_err  [2];
    logic          m_swap [2];
    logic          m_rvld [2];
    logic          m_rdy  [2];
    logic          m_rknown [2];
    int            m_cnt  [2];
    logic [15:0]   m_drop [2];
    logic [DW-1:0] m_rdat [2];
    logic [DW-1:0] m_mem  [2][2][8];
    bit            m_known[2][2][8];

    int n_cmp = 0;
    int n_err = 0;

    // Advance the model by one clock edge using the inputs now on the pins
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   np;
            bit   dm;
            logic rb;
            logic hs;
            logic sw;
            np = (k == 0) ? 8 : 6;
            dm = (k == 1);
            if (!i_rstn) begin
                m_bank[k] = 1'b0; m_hold[k] = 1'b0; m_act[k] = 1'b0; m_cnt[k] = 0;
                m_err[k] = 1'b0; m_drop[k] = '0; m_swap[k] = 1'b0; m_rvld[k] = 1'b0;
                m_rdat[k] = '0; m_rknown[k] = 1'b1; m_rdy[k] = 1'b1;
            end else begin
                rb = ~m_bank[k];
                m_rvld[k] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) >= np) begin
                        m_rdat[k] = '0;
                        m_rknown[k] = 1'b1;
                    end else begin
                        m_rdat[k] = m_mem[k][rb][rd_addr];
                        m_rknown[k] = m_known[k][rb][rd_addr];
                    end
                end
                hs = valid && m_rdy[k];
                sw = frame_start && m_hold[k];
                if (hs) begin
                    if (m_hold[k]) begin
                        if (sof && dm && m_drop[k] != 16'hFFFF) m_drop[k] = m_drop[k] + 16'd1;
                    end else if (sof) begin
                        if (m_act[k]) m_err[k] = 1'b1;
                        m_mem[k][m_bank[k]][0] = data;
                        m_known[k][m_bank[k]][0] = 1'b1;
                        m_cnt[k] = 1;
                        m_act[k] = 1'b1;
                    end else if (m_act[k]) begin
                        m_mem[k][m_bank[k]][m_cnt[k]] = data;
                        m_known[k][m_bank[k]][m_cnt[k]] = 1'b1;
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == np) begin
                            m_hold[k] = 1'b1;
                            m_act[k] = 1'b0;
                            m_cnt[k] = 0;
                        end
                    end
                end
                if (sw) begin
                    m_bank[k] = ~m_bank[k];
                    m_hold[k] = 1'b0;
                end
                m_swap[k] = sw;
                m_rdy[k] = !(m_hold[k] && !dm);
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("ready",    k, 32'(rdy[k]),  32'(m_rdy[k]));
            chk("swap",     k, 32'(swp[k]),  32'(m_swap[k]));
            chk("wr_bank",  k, 32'(bank[k]), 32'(m_bank[k]));
            chk("sync_err", k, 32'(serr[k]), 32'(m_err[k]));
            chk("drop_cnt", k, 32'(k != 0 ? drp1 : drp0), 32'(m_drop[k]));
            chk("rd_valid", k, 32'(rvld[k]), 32'(m_rvld[k]));
            if (m_rvld[k] && m_rknown[k])
                chk("rd_data", k, 32'(k != 0 ? rdat1 : rdat0), 32'(m_rdat[k]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge i_clk);
        @(negedge i_clk);
        check_all();
    endtask

    task automatic pix(input logic [DW-1:0] d, input logic s);
        valid = 1'b1; data = d; sof = s;
        step();
        valid = 1'b0; sof = 1'b0;
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) pix(DW'($urandom), i == 0);
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 8; a++) begin
                    m_known[k][b][a] = 1'b0;
                    m_mem[k][b][a] = '0;
                end
        i_rstn = 1'b0; valid = 1'b0; sof = 1'b0; rd_en = 1'b0;
        frame_start = 1'b0; data = '0; rd_addr = '0;

        // Reset state
        step(); step();
        i_rstn = 1'b1;
        chk("rst_ready", 0, 32'(rdy), 32'h3);
        chk("rst_bank",  0, 32'(bank), 32'h0);
        chk("rst_swap",  0, 32'(swp), 32'h0);
        chk("rst_rvld",  0, 32'(rvld), 32'h0);
        chk("rst_rdat",  0, 32'(rdat0), 32'h0);
        chk("rst_drop",  1, 32'(drp1), 32'h0);

        // Fill a frame 1..8, swap, read it back
        for (int i = 0; i < 8; i++) pix(DW'(i + 1), i == 0);
        fs();
        chk("swap_pulse", 0, 32'(swp[0]), 32'h1);
        chk("swap_bank",  0, 32'(bank[0]), 32'h1);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            chk("readback", 0, 32'(rdat0), 32'(i + 1));
            chk("readback_vld", 0, 32'(rvld[0]), 32'h1);
        end

        // Backpressure while the finished frame waits for a frame start
        frame(8);
        valid = 1'b1; data = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_ready", 0, 32'(rdy[0]), 32'h0);
        end
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("release_ready", 0, 32'(rdy[0]), 32'h1);
        step();
        valid = 1'b0;

        // Discard mode: three frames dropped while a frame is held
        frame(8);
        for (int f = 0; f < 3; f++) frame(6);
        chk("drop_three", 1, 32'(drp1), 32'h3);
        for (int i = 0; i < 8; i++) rd(3'(i));
        fs();

        // Early start-of-frame
        pix(12'h111, 1'b1); pix(12'h222, 1'b0); pix(12'h333, 1'b0);
        pix(12'hABC, 1'b1);
        chk("sync_err", 0, 32'(serr[0]), 32'h1);
        chk("sync_err", 1, 32'(serr[1]), 32'h1);
        for (int i = 0; i < 7; i++) pix(DW'(i + 16), 1'b0);
        chk("resync_full", 0, 32'(rdy[0]), 32'h0);
        fs();
        rd(3'd0);
        chk("resync_addr0", 0, 32'(rdat0), 32'hABC);

        // Frame start coincident with the last handshake does not swap
        frame(7);
        frame_start = 1'b1;
        pix(DW'($urandom), 1'b0);
        frame_start = 1'b0;
        chk("coincident_noswap", 0, 32'(swp[0]), 32'h0);
        step();
        chk("coincident_noswap2", 0, 32'(swp[0]), 32'h0);
        fs();
        chk("late_swap", 0, 32'(swp[0]), 32'h1);

        // Out-of-range reads and mid-frame reset
        rd(3'd7);
        chk("oor_data7", 1, 32'(rdat1), 32'h0);
        chk("oor_vld7",  1, 32'(rvld[1]), 32'h1);
        rd(3'd6);
        chk("oor_data6", 1, 32'(rdat1), 32'h0);
        frame(3);
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        chk("rst_mid_bank",  0, 32'(bank), 32'h0);
        chk("rst_mid_ready", 0, 32'(rdy), 32'h3);
        for (int i = 0; i < 3; i++) pix(DW'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) rd(3'(i));

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            i_rstn      = ($urandom_range(0, 399) != 0);
            valid       = ($urandom_range(0, 3) != 0);
            sof         = ($urandom_range(0, 11) == 0);
            data        = DW'($urandom);
            rd_en       = $urandom_range(0, 1) == 1;
            rd_addr     = 3'($urandom);
            frame_start = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
